// File: rtl/trace_pkg.sv
// Shared record format for the trace capture path: record types, the packed
// 64-bit record layout and a packing helper.
package trace_pkg;

  localparam int REC_W = 64;
  localparam int TS_W  = 16;

  typedef enum logic [1:0] {
    REG    = 2'd0,
    MEM_WR = 2'd1,
    MEM_RD = 2'd2,
    OVF    = 2'd3
  } trace_type_e;

  typedef struct packed {
    trace_type_e       rec_type;  // [63:62]
    logic [TS_W-1:0]   ts;        // [61:46]
    logic [4:0]        rsvd;      // [45:41]
    logic [8:0]        index;     // [40:32]
    logic [31:0]       data;      // [31:0]
  } trace_rec_t;

  function automatic trace_rec_t make_rec(
    input trace_type_e     t,
    input logic [TS_W-1:0] ts,
    input logic [8:0]      index,
    input logic [31:0]     data
  );
    trace_rec_t r;
    r.rec_type = t;
    r.ts       = ts;
    r.rsvd     = '0;
    r.index    = index;
    r.data     = data;
    return r;
  endfunction

endpackage

// File: rtl/trace_fifo_mw.sv
// Multi-write (0..3 entries per cycle), single-read FIFO. The caller guarantees
// it never pushes beyond free space and never pops when empty.
module trace_fifo_mw #(
  parameter int  DEPTH = 16,
  parameter type T     = logic [63:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             i_push_cnt,
  input  T                       i_wdata0,
  input  T                       i_wdata1,
  input  T                       i_wdata2,
  input  logic                   i_pop,
  output T                       o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  T                   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic [PTR_W-1:0]   w_wr_ptr1;
  logic [PTR_W-1:0]   w_wr_ptr2;

  assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);
  assign w_wr_ptr2 = r_wr_ptr + PTR_W'(2);

  // NOTE: storage has no reset; r_count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (i_push_cnt > 2'd0) r_mem[r_wr_ptr]  <= i_wdata0;
    if (i_push_cnt > 2'd1) r_mem[w_wr_ptr1] <= i_wdata1;
    if (i_push_cnt > 2'd2) r_mem[w_wr_ptr2] <= i_wdata2;
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(i_push_cnt);
      r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop);
      r_count  <= r_count + (PTR_W+1)'(i_push_cnt) - (PTR_W+1)'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/trace_capture.sv
// Observation-interface trace capture: timestamps register-writeback and
// data-memory events, buffers 64-bit records and streams them out.
module trace_capture #(
  parameter int DEPTH = 16,
  parameter int TS_W  = 16,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   reg_write_sig,
  input  logic [4:0]             reg_num,
  input  logic [31:0]            reg_data,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [8:0]             addr,
  input  logic [31:0]            wr_data,
  input  logic [31:0]            rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       dropped
);

  import trace_pkg::*;

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [TS_W-1:0]  r_ts;
  logic [CNT_W-1:0] r_dropped;
  logic             r_pending;

  logic             w_mem_ev;
  logic             w_reg_ev;
  logic [1:0]       w_n;
  logic [1:0]       w_need;
  logic [LVL_W-1:0] w_level;
  logic [LVL_W-1:0] w_free;
  logic             w_fit;
  logic             w_pop;
  logic [1:0]       w_push_cnt;
  logic [CNT_W:0]   w_drop_sum;
  logic [CNT_W-1:0] w_drop_nxt;
  trace_rec_t       w_mem_rec;
  trace_rec_t       w_reg_rec;
  trace_rec_t       w_ovf_rec;
  trace_rec_t       w_slot0;
  trace_rec_t       w_slot1;
  trace_rec_t       w_slot2;
  trace_rec_t       w_head;

  // A simultaneous load and store is illegal and produces no event at all.
  assign w_mem_ev = en && (wr ^ rd);
  assign w_reg_ev = en && reg_write_sig;
  assign w_n      = 2'(w_mem_ev) + 2'(w_reg_ev);
  assign w_need   = w_n + 2'(r_pending);

  // Free space comes from the registered level; a pop this cycle frees a slot
  // only for next cycle's arbitration.
  assign w_free = LVL_W'(DEPTH) - w_level;
  assign w_fit  = (LVL_W'(w_need) <= w_free);

  assign w_mem_rec = make_rec(wr ? MEM_WR : MEM_RD, r_ts, addr,
                              wr ? wr_data : rd_data);
  assign w_reg_rec = make_rec(REG, r_ts, {4'b0, reg_num}, reg_data);
  assign w_ovf_rec = make_rec(OVF, r_ts, 9'd0, 32'(r_dropped));

  // Slot order is OVF, then mem, then reg, compacted over absent candidates.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_push_cnt = 2'd0;
    w_slot0    = w_reg_rec;
    w_slot1    = w_reg_rec;
    w_slot2    = w_reg_rec;
    if (w_fit) begin
      w_push_cnt = w_need;
    end
    if (r_pending) begin
      w_slot0 = w_ovf_rec;
      w_slot1 = w_mem_ev ? w_mem_rec : w_reg_rec;
    end else begin
      w_slot0 = w_mem_ev ? w_mem_rec : w_reg_rec;
    end
  end

  assign w_drop_sum = {1'b0, r_dropped} + (CNT_W+1)'(w_n);
  assign w_drop_nxt = w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ts      <= '0;
      r_dropped <= '0;
      r_pending <= 1'b0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      if (w_fit) begin
        if (r_pending) begin
          r_pending <= 1'b0;
          r_dropped <= '0;
        end
      end else if (w_n != 2'd0) begin
        // All-or-nothing: a cycle's events are never partially accepted.
        r_pending <= 1'b1;
        r_dropped <= w_drop_nxt;
      end
    end
  end

  assign w_pop = out_valid && out_ready;

  trace_fifo_mw #(
    .DEPTH (DEPTH),
    .T     (trace_rec_t)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .i_push_cnt (w_push_cnt),
    .i_wdata0   (w_slot0),
    .i_wdata1   (w_slot1),
    .i_wdata2   (w_slot2),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_level)
  );

  assign out_valid = (w_level != '0);
  assign out_data  = out_valid ? w_head : '0;
  assign level     = w_level;
  assign dropped   = r_dropped;

endmodule
